// File: rtl/rtc_tick_gen.sv
// rtc_tick_gen: conditioning and prescale stage in front of the RTC counter.
// An asynchronous timebase is brought into the clk domain by a synchronizer.
// It is then glitch-filtered and its rising edges are detected. The edge rate
// is divided by a runtime-programmable ratio, and the result drives the
// counter's trig input as clean single-cycle pulses.
//
// Timing with div_q = 1: ext_in is first sampled high at clk edge 1, and trig
// is high for exactly one cycle after edge SYNC_STAGES + FILT + 1.

module rtc_tick_gen #(
    parameter int WIDTH       = 4,   // divisor / prescale counter width
    parameter int SYNC_STAGES = 2,   // synchronizer depth, 2 or more
    parameter int FILT        = 3,   // stable cycles before filt changes, 0 = bypass
    parameter int DIV_RESET   = 1    // divisor held in div_q after reset
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active-low
    input  logic             ext_in,   // asynchronous timebase / pulse source
    input  logic             en,       // prescaler enable
    input  logic [WIDTH-1:0] div,      // divide ratio, 0 behaves as 1
    output logic             trig,     // one-cycle pulse every div_q edges
    output logic [WIDTH-1:0] phase,    // current prescale count
    output logic             ovr       // sticky: edge arrived while trig high
);

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s_out;

    // Shift ext_in through SYNC_STAGES flops to resolve metastability.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ext_in};
        end
    end

    assign w_s_out = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Glitch filter
    // ------------------------------------------------------------------
    logic w_filt;

    generate
        if (FILT == 0) begin : g_no_filt
            // Bypass: the filtered level is the synchronizer output itself.
            assign w_filt = w_s_out;
        end else begin : g_filt
            localparam int FCW = (FILT > 1) ? $clog2(FILT) : 1;

            logic [FCW-1:0] r_fcnt;
            logic           r_filt;
            logic [FCW-1:0] w_fcnt_nxt;
            logic           w_filt_nxt;

            // Count consecutive cycles in which s_out disagrees with filt and
            // accept the new level once the disagreement has lasted FILT cycles.
            always_comb begin
                w_fcnt_nxt = r_fcnt;
                w_filt_nxt = r_filt;
                if (w_s_out == r_filt) begin
                    w_fcnt_nxt = {FCW{1'b0}};
                end else if (r_fcnt == FCW'(FILT - 1)) begin
                    w_filt_nxt = w_s_out;
                    w_fcnt_nxt = {FCW{1'b0}};
                end else begin
                    w_fcnt_nxt = r_fcnt + FCW'(1);
                end
            end

            // Filter state registers.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_fcnt <= {FCW{1'b0}};
                    r_filt <= 1'b0;
                end else begin
                    r_fcnt <= w_fcnt_nxt;
                    r_filt <= w_filt_nxt;
                end
            end

            assign w_filt = r_filt;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Rising-edge detect
    // ------------------------------------------------------------------
    logic r_filt_d;
    logic w_edge;

    // Delayed copy of the filtered level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt_d <= 1'b0;
        end else begin
            r_filt_d <= w_filt;
        end
    end

    // Only rising edges advance the prescaler; falling edges are ignored.
    assign w_edge = w_filt & ~r_filt_d;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_div_q;
    logic [WIDTH-1:0] r_phase;
    logic             r_trig;
    logic             r_ovr;

    logic [WIDTH-1:0] w_eff_div;
    logic [WIDTH-1:0] w_div_q_eff;
    logic             w_last;
    logic [WIDTH-1:0] w_div_q_nxt;
    logic [WIDTH-1:0] w_phase_nxt;
    logic             w_trig_nxt;
    logic             w_ovr_nxt;

    // A zero ratio is treated as divide-by-one, both on the input and in the
    // latched copy, so the wrap compare below can never underflow.
    assign w_eff_div   = (div == {WIDTH{1'b0}}) ? WIDTH'(1) : div;
    assign w_div_q_eff = (r_div_q == {WIDTH{1'b0}}) ? WIDTH'(1) : r_div_q;
    assign w_last      = (r_phase == (w_div_q_eff - WIDTH'(1)));

    // Prescaler next state. The priority is: disabled, then a wrapping edge,
    // then a counting edge, then idle. The divisor is latched only while
    // disabled or at wrap, so a div change never corrupts a count in progress.
    always_comb begin
        w_div_q_nxt = r_div_q;
        w_phase_nxt = r_phase;
        w_trig_nxt  = 1'b0;
        if (!en) begin
            w_phase_nxt = {WIDTH{1'b0}};
            w_trig_nxt  = 1'b0;
            w_div_q_nxt = w_eff_div;
        end else if (w_edge && w_last) begin
            w_phase_nxt = {WIDTH{1'b0}};
            w_trig_nxt  = 1'b1;
            w_div_q_nxt = w_eff_div;
        end else if (w_edge) begin
            w_phase_nxt = r_phase + WIDTH'(1);
            w_trig_nxt  = 1'b0;
        end else begin
            w_phase_nxt = r_phase;
            w_trig_nxt  = 1'b0;
        end
    end

    // Overrun is sticky until reset: an edge seen while trig is still high.
    always_comb begin
        if (w_edge && r_trig) begin
            w_ovr_nxt = 1'b1;
        end else begin
            w_ovr_nxt = r_ovr;
        end
    end

    // Prescaler and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_q <= WIDTH'(DIV_RESET);
            r_phase <= {WIDTH{1'b0}};
            r_trig  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_div_q <= w_div_q_nxt;
            r_phase <= w_phase_nxt;
            r_trig  <= w_trig_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    assign trig  = r_trig;
    assign phase = r_phase;
    assign ovr   = r_ovr;

endmodule

// File: tb/tb_rtc_tick_gen.sv
// Testbench for rtc_tick_gen. A cycle-level behavioural model predicts trig,
// phase and ovr, and the outputs are compared against it on every falling
// clk edge. Directed scenarios add literal expectations, followed by a
// randomized pulse stream.

module tb_rtc_tick_gen;

    localparam int WIDTH     = 4;
    localparam int SYNC      = 2;
    localparam int FILT      = 3;
    localparam int DIV_RESET = 1;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             ext_in = 1'b0;
    logic             en     = 1'b0;
    logic [WIDTH-1:0] div    = 4'd1;
    logic             trig;
    logic [WIDTH-1:0] phase;
    logic             ovr;

    rtc_tick_gen #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC),
        .FILT        (FILT),
        .DIV_RESET   (DIV_RESET)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ext_in (ext_in),
        .en     (en),
        .div    (div),
        .trig   (trig),
        .phase  (phase),
        .ovr    (ovr)
    );

    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int trig_cnt = 0;
    int t0       = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // The synchronizer is a history of samples, the filter a run length of
    // disagreeing samples, and the prescaler an edge count modulo the ratio.
    // ------------------------------------------------------------------
    bit q_hist[$];
    bit m_filt, m_filt_d, m_trig, m_ovr;
    bit s_old, m_edge_v;
    int m_run, m_count, m_div;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_hist.delete();
            m_filt   = 1'b0;
            m_filt_d = 1'b0;
            m_trig   = 1'b0;
            m_ovr    = 1'b0;
            m_run    = 0;
            m_count  = 0;
            m_div    = DIV_RESET;
        end else begin
            s_old    = (q_hist.size() >= SYNC) ? q_hist[SYNC-1] : 1'b0;
            m_edge_v = m_filt && !m_filt_d;
            if (m_edge_v && m_trig) m_ovr = 1'b1;
            if (!en) begin
                m_count = 0;
                m_trig  = 1'b0;
                m_div   = eff(int'(div));
            end else if (m_edge_v) begin
                if (m_count + 1 == eff(m_div)) begin
                    m_count = 0;
                    m_trig  = 1'b1;
                    m_div   = eff(int'(div));
                end else begin
                    m_count = m_count + 1;
                    m_trig  = 1'b0;
                end
            end else begin
                m_trig = 1'b0;
            end
            m_filt_d = m_filt;
            if (s_old != m_filt) begin
                m_run = m_run + 1;
                if (m_run == FILT) begin
                    m_filt = s_old;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            q_hist.push_front(ext_in);
            if (q_hist.size() > SYNC) void'(q_hist.pop_back());
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("trig",  int'(trig),  int'(m_trig));
            check("phase", int'(phase), m_count);
            check("ovr",   int'(ovr),   int'(m_ovr));
            if (trig) trig_cnt++;
        end
    end

    task automatic pulse(input int hi, input int lo);
        ext_in = 1'b1;
        repeat (hi) @(negedge clk);
        ext_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        // 1. Reset defaults and latency.
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_trig",  int'(trig),  0);
        check("rst_phase", int'(phase), 0);
        check("rst_ovr",   int'(ovr),   0);
        en  = 1'b1;
        div = 4'd1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        ext_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("latency_edge%0d", k), int'(trig), (k == 6) ? 1 : 0);
        end
        ext_in = 1'b0;
        repeat (10) @(negedge clk);

        // 2. Divide-by-5 over 17 clean pulses.
        en  = 1'b0;
        div = 4'd5;
        @(negedge clk);
        en = 1'b1;
        #1 t0 = trig_cnt;
        repeat (17) pulse(6, 6);
        #1;
        check("div5_trigs", trig_cnt - t0, 3);
        check("div5_phase", int'(phase), 2);

        // 3. Glitch rejection: 2 cycles dropped, 4 cycles counted.
        t0 = trig_cnt;
        pulse(2, 10);
        #1;
        check("glitch_phase", int'(phase), 2);
        check("glitch_trigs", trig_cnt - t0, 0);
        pulse(4, 10);
        #1;
        check("pulse4_phase", int'(phase), 3);

        // 4. Runtime div change takes effect at wrap.
        en  = 1'b0;
        div = 4'd4;
        @(negedge clk);
        en = 1'b1;
        #1 t0 = trig_cnt;
        pulse(6, 6);
        pulse(6, 6);
        div = 4'd2;
        for (int e = 3; e <= 6; e++) begin
            pulse(6, 6);
            #1;
            check($sformatf("divchg_edge%0d", e), trig_cnt - t0,
                  (e < 4) ? 0 : ((e < 6) ? 1 : 2));
        end

        // 5. Disabled prescaler discards edges, then div=0 acts as 1.
        en = 1'b0;
        #1 t0 = trig_cnt;
        for (int i = 0; i < 10; i++) begin
            pulse(6, 6);
            #1;
            check("disabled_phase", int'(phase), 0);
        end
        check("disabled_trigs", trig_cnt - t0, 0);
        div = 4'd0;
        @(negedge clk);
        en = 1'b1;
        #1 t0 = trig_cnt;
        for (int i = 0; i < 4; i++) begin
            pulse(6, 6);
            #1;
            check("div0_trigs", trig_cnt - t0, i + 1);
        end
        check("div0_ovr", int'(ovr), 0);

        // 6. Asynchronous reset mid-count.
        en  = 1'b0;
        div = 4'd8;
        @(negedge clk);
        en = 1'b1;
        repeat (5) pulse(6, 6);
        #1;
        check("pre_reset_phase", int'(phase), 5);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_phase", int'(phase), 0);
        check("arst_trig",  int'(trig),  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        en = 1'b1;
        #1 t0 = trig_cnt;
        repeat (7) pulse(6, 6);
        #1;
        check("post_reset_7", trig_cnt - t0, 0);
        pulse(6, 6);
        #1;
        check("post_reset_8", trig_cnt - t0, 1);

        // Randomized stream: ratios, enables, glitches and occasional resets.
        repeat (300) begin
            div = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 9) != 0);
            pulse(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)));
            if ($urandom_range(0, 49) == 0) begin
                @(posedge clk);
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        repeat (12) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
